// File: rtl/multi_queue.sv
// multi_queue: in-order request queue with a per-request retire latency.
// Each entry retires lat cycles after it first becomes the queue head.
module multi_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LAT_W = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    input  logic [LAT_W-1:0] lat,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LAT_W-1:0] lat;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LAT_W-1:0] timer_q, timer_d;
    logic             accept;
    logic             empty;
    entry_t           head;

    assign empty  = (count_q == '0);
    assign ready  = (count_q != FULL);
    assign accept = start & ready;
    assign head   = mem_q[rd_ptr_q];
    assign done   = ~empty & (timer_q == head.lat);
    assign out    = done ? head.data : '0;
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (done)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({accept, done})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Timer restarts for every new head; idle while the queue is empty.
    always_comb begin
        timer_d = timer_q + LAT_W'(1);
        if (empty || done) timer_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) mem_q[wr_ptr_q] <= {inp, lat};
    end

endmodule

// File: tb/tb_multi_queue.sv
// Self-checking bench for multi_queue: scoreboard of expected retires
// plus per-scenario cycle-exact checks.
module tb_multi_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LAT_W = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] inp   = '0;
    logic [LAT_W-1:0] lat   = '0;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [CNT_W-1:0] count;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               acc;
        int               fin;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   last_done = 0;
    int   mon_n;
    bit   mon_en    = 1'b0;

    multi_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .LAT_W(LAT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .inp  (inp),
        .lat  (lat),
        .ready(ready),
        .done (done),
        .out  (out),
        .count(count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of stimulus; accepted requests get a modelled retire cycle.
    task automatic drive(input bit s, input logic [WIDTH-1:0] d, input int l);
        int h;
        start = s;
        inp   = d;
        lat   = LAT_W'(l);
        if (s && !reset && sb.size() < DEPTH) begin
            h = (cyc + 1 > last_done + 1) ? cyc + 1 : last_done + 1;
            last_done = h + l;
            sb.push_back('{data: d, acc: cyc, fin: h + l});
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            mon_n = 0;
            foreach (sb[i]) if (sb[i].acc < cyc) mon_n++;
            checks++;
            if (count !== CNT_W'(mon_n)) begin
                failures++;
                $display("FAIL mon_count cyc=%0d got=%0d exp=%0d", cyc, count, mon_n);
            end
            checks++;
            if (ready !== 1'(mon_n < DEPTH)) begin
                failures++;
                $display("FAIL mon_ready cyc=%0d got=%0b exp=%0b", cyc, ready, mon_n < DEPTH);
            end
            if (sb.size() > 0 && sb[0].fin == cyc) begin
                checks++;
                if (done !== 1'b1 || out !== sb[0].data) begin
                    failures++;
                    $display("FAIL mon_retire cyc=%0d got done=%0b out=%h exp done=1 out=%h",
                             cyc, done, out, sb[0].data);
                end
                void'(sb.pop_front());
            end else begin
                checks++;
                if (done !== 1'b0 || out !== '0) begin
                    failures++;
                    $display("FAIL mon_idle cyc=%0d got done=%0b out=%h exp done=0 out=0",
                             cyc, done, out);
                end
            end
        end
    end

    task automatic wait_drain;
        start = 1'b0;
        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            step;
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        sb.delete();
        last_done = 0;
        step;
        step;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%0b exp=1", ready);
        end
        checks++;
        if (count !== '0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%0b exp=0", done);
        end
        checks++;
        if (out !== '0) begin
            failures++; $display("FAIL reset_out got=%h exp=0", out);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single;
        step;
        drive(1'b1, 32'hDEADBEEF, 1);
        @(negedge clock);
        step;
        drive(1'b0, '0, 0);
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || out !== '0) begin
            failures++; $display("FAIL single_c1 got done=%0b out=%h exp 0/0", done, out);
        end
        step;
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_c2 got done=%0b out=%h exp 1/deadbeef", done, out);
        end
        step;
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || out !== '0) begin
            failures++; $display("FAIL single_c3 got done=%0b out=%h exp 0/0", done, out);
        end
        wait_drain;
    endtask

    task automatic test_fill;
        logic [WIDTH-1:0] pay [5];
        int               lats [5];
        logic [WIDTH-1:0] exp_out [11];
        pay     = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004, 32'hE000_0005};
        lats    = '{3, 0, 2, 0, 1};
        exp_out = '{0, 0, 0, 0, 32'hA000_0001, 32'hB000_0002, 0, 0,
                    32'hC000_0003, 32'hD000_0004, 0};
        for (int k = 0; k <= 10; k++) begin
            step;
            if (k < 5) drive(1'b1, pay[k], lats[k]);
            else       drive(1'b0, '0, 0);
            @(negedge clock);
            if (k == 4) begin
                checks++;
                if (ready !== 1'b0) begin
                    failures++; $display("FAIL fill_ready c4 got=%0b exp=0", ready);
                end
            end
            checks++;
            if (done !== 1'(exp_out[k] != 0) || out !== exp_out[k]) begin
                failures++;
                $display("FAIL fill_done c%0d got done=%0b out=%h exp out=%h",
                         k, done, out, exp_out[k]);
            end
            if (k == 10) begin
                checks++;
                if (count !== '0) begin
                    failures++; $display("FAIL fill_count c10 got=%0d exp=0", count);
                end
            end
        end
        wait_drain;
    endtask

    task automatic test_full_done;
        int lats [4];
        lats = '{3, 5, 5, 5};
        for (int k = 0; k <= 6; k++) begin
            step;
            if (k < 4)       drive(1'b1, WIDTH'(32'h5100 + k), lats[k]);
            else if (k == 4) drive(1'b1, 32'hF00D_0004, 1);
            else if (k == 5) drive(1'b1, 32'hF00D_0005, 1);
            else             drive(1'b0, '0, 0);
            @(negedge clock);
            if (k == 4) begin
                checks++;
                if (done !== 1'b1 || ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_done c4 got done=%0b ready=%0b exp 1/0", done, ready);
                end
            end
            if (k == 5) begin
                checks++;
                if (count !== CNT_W'(DEPTH - 1)) begin
                    failures++; $display("FAIL full_count c5 got=%0d exp=%0d", count, DEPTH - 1);
                end
            end
            if (k == 6) begin
                checks++;
                if (count !== CNT_W'(DEPTH)) begin
                    failures++; $display("FAIL full_refill c6 got=%0d exp=%0d", count, DEPTH);
                end
            end
        end
        wait_drain;
    endtask

    task automatic test_wrap;
        int issued = 0;
        int seen   = 0;
        for (int k = 0; k < 40 && seen < 10; k++) begin
            step;
            if (issued < 10) begin
                drive(1'b1, WIDTH'(32'h1000 + issued), 0);
                if (ready) issued++;
            end else begin
                drive(1'b0, '0, 0);
            end
            @(negedge clock);
            if (done) begin
                checks++;
                if (out !== WIDTH'(32'h1000 + seen)) begin
                    failures++;
                    $display("FAIL wrap_order n=%0d got=%h exp=%h", seen, out, 32'h1000 + seen);
                end
                seen++;
            end
        end
        checks++;
        if (seen !== 10) begin
            failures++; $display("FAIL wrap_count got=%0d exp=10", seen);
        end
        wait_drain;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 3; k++) begin
            step;
            drive(1'b1, WIDTH'(32'hA0 + k), 9);
            @(negedge clock);
        end
        step;
        reset = 1'b1;
        sb.delete();
        last_done = 0;
        drive(1'b1, 32'h0000_0BAD, 0);
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL rmid_done_at_reset got=%0b exp=0", done);
        end
        step;
        reset = 1'b0;
        drive(1'b1, 32'h0000_5EED, 0);
        @(negedge clock);
        checks++;
        if (count !== '0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_cleared got count=%0d ready=%0b exp 0/1", count, ready);
        end
        step;
        drive(1'b0, '0, 0);
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || out !== 32'h0000_5EED) begin
            failures++;
            $display("FAIL rmid_new_req got done=%0b out=%h exp 1/00005eed", done, out);
        end
        for (int k = 0; k < 12; k++) begin
            step;
            @(negedge clock);
            checks++;
            if (done !== 1'b0) begin
                failures++; $display("FAIL rmid_stale_done k=%0d got=%0b exp=0", k, done);
            end
        end
        wait_drain;
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill;
        test_full_done;
        test_wrap;
        test_reset_mid;
        repeat (3) step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached limit, exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
